jstk_reader: RTL

Serial gamepad poller (SNES-style latch/clock/data, 16 buttons) that feeds the 16-bit jstk_state word to the system controller, which exposes it to the CPU as a read-only register. It periodically pulses the latch line and clocks out 16 bits, then presents a stable, active-high button word. It also emits a one-cycle update strobe when the word is refreshed.

---
 rtl/jstk_pkg.sv | 15 +
 rtl/sync2.sv | 22 ++
 rtl/jstk_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jstk_pkg.sv
// Shared types and constants for the serial gamepad poller.
package jstk_pkg;

    localparam int JSTK_NBITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        LOW,
        HIGH,
        DONE
    } jstk_fsm_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jstk_reader.sv
// Periodic SNES-style pad scan: latch pulse, 16 shift clocks, then a stable
// active-high button word with a one-cycle update strobe.
//
//   state | meaning
//   IDLE  | waiting for poll counter expiry with jstk_en high
//   LATCH | jstk_latch high for LATCH_CYC cycles
//   GAP   | latch low, clk high; bit 0 sampled on the last cycle
//   LOW   | jstk_clk low for HALF_CYC cycles
//   HIGH  | jstk_clk high for HALF_CYC cycles; next bit sampled on last cycle
//   DONE  | jstk_state refreshed, jstk_upd high for this single cycle
module jstk_reader
    import jstk_pkg::*;
#(
    parameter int LATCH_CYC = 144,
    parameter int HALF_CYC  = 72,
    parameter int POLL_CYC  = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jstk_en,
    output logic                  jstk_latch,
    output logic                  jstk_clk,
    input  logic                  jstk_data,
    output logic [JSTK_NBITS-1:0] jstk_state,
    output logic                  jstk_upd
);
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int POLL_W = $clog2(POLL_CYC);
    localparam int BIT_W  = $clog2(JSTK_NBITS);

    localparam logic [PH_W-1:0]   PH_LATCH    = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0]   PH_HALF     = PH_W'(HALF_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYC - 1);
    localparam logic [BIT_W-1:0]  LAST_PULSE  = BIT_W'(JSTK_NBITS - 1);

    jstk_fsm_e             state;
    logic [PH_W-1:0]       phase;
    logic [POLL_W-1:0]     poll_cnt;
    logic [BIT_W-1:0]      pulse;
    logic [BIT_W-1:0]      next_bit;
    logic [JSTK_NBITS-1:0] shift_reg;
    logic                  data_s;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (jstk_data),
        .q   (data_s)
    );

    assign next_bit = pulse + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            poll_cnt   <= '0;
            pulse      <= '0;
            shift_reg  <= '0;
            jstk_latch <= 1'b0;
            jstk_clk   <= 1'b1;
            jstk_state <= '0;
            jstk_upd   <= 1'b0;
        end else begin
            jstk_upd <= 1'b0;
            // Poll counter runs in every state and saturates at zero.
            if (poll_cnt != '0)
                poll_cnt <= poll_cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (jstk_en && poll_cnt == '0) begin
                        state      <= LATCH;
                        phase      <= PH_LATCH;
                        poll_cnt   <= POLL_RELOAD;
                        jstk_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase == '0) begin
                        state      <= GAP;
                        phase      <= PH_HALF;
                        jstk_latch <= 1'b0;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                GAP: begin
                    if (phase == '0) begin
                        shift_reg[0] <= data_s;
                        state        <= LOW;
                        phase        <= PH_HALF;
                        pulse        <= '0;
                        jstk_clk     <= 1'b0;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                LOW: begin
                    if (phase == '0) begin
                        state    <= HIGH;
                        phase    <= PH_HALF;
                        jstk_clk <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == '0) begin
                        if (pulse == LAST_PULSE) begin
                            // Word and strobe land together in the DONE cycle.
                            state      <= DONE;
                            phase      <= '0;
                            jstk_state <= ~shift_reg;
                            jstk_upd   <= 1'b1;
                        end else begin
                            shift_reg[next_bit] <= data_s;
                            pulse               <= next_bit;
                            state               <= LOW;
                            phase               <= PH_HALF;
                            jstk_clk            <= 1'b0;
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
